spi_slave_regs: RTL
===================

Name: spi_slave_regs

Overview:
- Soft SPI responder (mode 0, MSB first): the far end of the SB_SPI master links driven by system_bus.
- Lets an external SPI master read and write a 128-entry byte register space owned by local fabric logic.
- Oversamples the SPI pins in the system clock domain and exposes a one-cycle register strobe port.
- Sits behind SB_IO pads; a sibling FPGA or a loopback bench acts as the master.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on spi_sclk, spi_mosi and spi_cs_n (minimum 2).
- CMD_FILL, 8'h00, byte shifted out on MISO during the command byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- spi_sclk  in  1  SPI clock from the master (asynchronous to clk).
- spi_mosi  in  1  master-out data.
- spi_cs_n  in  1  active-low chip select.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  pad output enable for MISO.
- reg_addr  out  7  register address.
- reg_wdata  out  8  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data; valid 1 clk after reg_re.
- busy  out  1  high while a frame is active (synchronised cs_n low).

Behaviour:
- Reset (rst low): every output 0, spi_miso = CMD_FILL[7], state IDLE, bit count 0.
- Synchronisation: all three SPI inputs pass through SYNC_STAGES flops. Edges are detected on synced sclk.
  - Rising edge: sample mosi into the rx shift register.
  - Falling edge: shift tx, then spi_miso = tx[7].
- Timing: the SPI clock rate must not exceed clk/16.
- Frame protocol:
  - First byte is the command: bit7 = 1 read / 0 write; bits 6:0 = start address.
  - Following bytes are data, with the address auto-incrementing mod 128 (7'h7F wraps to 7'h00).
- States: IDLE, CMD, WDATA, RDATA.
- IDLE -> CMD when synced cs_n falls:
  - busy = 1, spi_miso_oe = 1.
  - tx loaded with CMD_FILL, bit count cleared.
- CMD, on the 8th rising edge:
  - Latch the address into reg_addr.
  - Write command -> WDATA.
  - Read command -> RDATA, with reg_re pulsed on the next clk. reg_rdata is captured 1 clk later into tx, and spi_miso = bit 7 immediately, without waiting for a falling edge.
- WDATA, each 8th rising edge:
  - reg_wdata = received byte; reg_we pulses for 1 clk with the current reg_addr.
  - reg_addr increments on the following clk.
- RDATA, each 8th rising edge:
  - reg_addr increments, then reg_re pulses for the new address.
  - tx is loaded from reg_rdata as described for CMD.
  - This prefetch produces one extra reg_re at frame end; local logic must tolerate side-effect-free reads.
- Simultaneous events: reg_we and reg_re are never asserted together. At most one strobe fires per received byte.
- Synced cs_n rising, any state:
  - Go to IDLE; busy = 0, spi_miso_oe = 0, bit count = 0.
  - A partial byte (<8 bits) is discarded with no strobe.
  - A strobe already issued in that cycle completes.
- cs_n high with sclk toggling: ignored; no state change.
- Reset asserted mid-frame: immediate return to reset values. The frame continues only after cs_n cycles high then low.

Decomposition:
- Shared package holds:
  - state enum (IDLE, CMD, WDATA, RDATA);
  - command field constants: CMD_RW_BIT = 7, ADDR_W = 7;
  - the minimum oversample ratio, 16.
- One natural sub-module: spi_pin_sync. It contains the SYNC_STAGES synchronisers plus sclk rise/fall edge pulses and the cs_n fall/rise pulses.

Test Plan:
- Write burst: cs_n low; send 8'h05, 8'hA1, 8'hB2; cs_n high -> reg_we at addr 5 with A1, then addr 6 with B2; no reg_re; busy drops within 4 clk of cs_n.
- Read burst: regfile[10]=8'h3C, [11]=8'hC3; send 8'h8A + two dummy bytes -> MISO returns 8'h00, 3C, C3; reg_re at addr 10, 11, 12.
- Wrap: write command 8'h7F with data 8'h11, 8'h22 -> writes addr 7F = 11, then addr 00 = 22.
- Abort: cs_n high after command 8'h03 plus 5 data bits -> no reg_we; spi_miso_oe = 0; the next frame decodes its command correctly.
- Reset mid-read: drop rst during the second data byte -> all outputs 0 asynchronously; after release plus a cs_n toggle, a read of 8'h8A returns regfile[10].
- Max rate: sclk = clk/16 on a 4-byte read -> every MISO bit is stable before each sclk rise; zero mismatches.

Source files
------------

// File: rtl/spi_slave_regs_pkg.sv
// Shared definitions for the SPI register responder.
//   - state_t        : frame decoder states
//   - command fields : CMD_RW_BIT (1 = read), ADDR_W (register address width)
//   - MIN_OVERSAMPLE : the slowest allowed clk-to-sclk ratio
//   - addr_inc       : register address auto-increment (wraps mod 2**ADDR_W)
package spi_slave_regs_pkg;

  localparam int BYTE_W         = 8;
  localparam int BIT_CNT_W      = 3;
  localparam int ADDR_W         = 7;
  localparam int CMD_RW_BIT     = 7;
  localparam int MIN_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/spi_slave_regs_if.sv
// Pin and register-port bundle of the SPI register responder.
//   SPI side      : spi_sclk, spi_mosi, spi_cs_n (to responder), spi_miso, spi_miso_oe (from it)
//   register side : reg_addr, reg_wdata, reg_we, reg_re (from responder), reg_rdata (to it)
//   status        : busy
// modport slave  : the responder itself.
// modport master : everything around it (the SPI master plus the local register fabric).
interface spi_slave_regs_if;
  import spi_slave_regs_pkg::*;

  logic                spi_sclk;
  logic                spi_mosi;
  logic                spi_cs_n;
  logic                spi_miso;
  logic                spi_miso_oe;
  logic [ADDR_W-1:0]   reg_addr;
  logic [BYTE_W-1:0]   reg_wdata;
  logic                reg_we;
  logic                reg_re;
  logic [BYTE_W-1:0]   reg_rdata;
  logic                busy;

  modport slave (
    input  spi_sclk, spi_mosi, spi_cs_n, reg_rdata,
    output spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

  modport master (
    output spi_sclk, spi_mosi, spi_cs_n, reg_rdata,
    input  spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

endinterface

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain and produces
// single-cycle edge pulses.
//   clk, rst          : system clock, asynchronous active-low reset
//   spi_sclk/mosi/cs_n: raw pins
//   mosi_s            : synchronised mosi, aligned with the sclk edge pulses
//   sclk_rise/fall    : one-cycle pulses on synchronised sclk edges
//   cs_fall/cs_rise   : one-cycle pulses on synchronised cs_n edges
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sclk,
  input  logic spi_mosi,
  input  logic spi_cs_n,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  // The cs_n chain resets to 0 (selected) on purpose: if reset is released
  // while the master still holds cs_n low, no falling edge is seen and the
  // interrupted frame is ignored until cs_n goes high and low again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end

  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise =  sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] &  sclk_prev;
  assign cs_rise   =  cs_sync[SYNC_STAGES-1]   & ~cs_prev;
  assign cs_fall   = ~cs_sync[SYNC_STAGES-1]   &  cs_prev;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder giving an external master byte access to a 128-entry
// register space. First byte of a frame is the command (bit7 = read,
// bits 6:0 = start address); following bytes are data with the address
// auto-incrementing. The SPI clock must be at most clk/16.
//   clk, rst : system clock, asynchronous active-low reset
//   bus      : spi_slave_regs_if.slave (SPI pins, register strobe port, busy)
// Parameters:
//   SYNC_STAGES : synchroniser depth on the SPI pins (>= 2)
//   CMD_FILL    : byte shifted out on MISO during the command byte
module spi_slave_regs
  import spi_slave_regs_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_FILL    = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  spi_slave_regs_if.slave    bus
);

  logic mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

  spi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk       (clk),
    .rst       (rst),
    .spi_sclk  (bus.spi_sclk),
    .spi_mosi  (bus.spi_mosi),
    .spi_cs_n  (bus.spi_cs_n),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  state_t                 state_q, state_n;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_n;
  logic [BYTE_W-1:0]      rx_q;
  logic [BYTE_W-1:0]      rx_byte;
  logic [BYTE_W-1:0]      tx_q, tx_n;
  logic                   miso_q, miso_n;
  logic                   oe_q, oe_n;
  logic                   busy_q, busy_n;
  logic [ADDR_W-1:0]      addr_q, addr_n;
  logic [BYTE_W-1:0]      wdata_q, wdata_n;
  logic                   we_q, we_n;
  logic                   re_q, re_n;
  logic                   rd_cap_q, rd_cap_n;   // reg_rdata is valid this cycle
  logic                   inc_pend_q, inc_pend_n; // bump address after a write strobe

  // Byte as it will look once the current rising-edge bit is shifted in.
  assign rx_byte = {rx_q[BYTE_W-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (sclk_rise) rx_q <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_q       <= CMD_FILL;
      miso_q     <= CMD_FILL[BYTE_W-1];
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      rd_cap_q   <= 1'b0;
      inc_pend_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      tx_q       <= tx_n;
      miso_q     <= miso_n;
      oe_q       <= oe_n;
      busy_q     <= busy_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      we_q       <= we_n;
      re_q       <= re_n;
      rd_cap_q   <= rd_cap_n;
      inc_pend_q <= inc_pend_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    tx_n       = tx_q;
    miso_n     = miso_q;
    oe_n       = oe_q;
    busy_n     = busy_q;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    we_n       = 1'b0;
    re_n       = 1'b0;
    rd_cap_n   = re_q;
    inc_pend_n = 1'b0;

    if (inc_pend_q) addr_n = addr_inc(addr_q);

    // Read data lands two clocks after the byte boundary, well before the
    // next sclk rise at the minimum oversample ratio, so MSB goes straight out.
    if (rd_cap_q && state_q == RDATA) begin
      tx_n   = bus.reg_rdata;
      miso_n = bus.reg_rdata[BYTE_W-1];
    end

    if (state_q == IDLE) begin
      if (cs_fall) begin
        state_n   = CMD;
        busy_n    = 1'b1;
        oe_n      = 1'b1;
        tx_n      = CMD_FILL;
        miso_n    = CMD_FILL[BYTE_W-1];
        bit_cnt_n = '0;
      end
    end else if (cs_rise) begin
      // Any partial byte is dropped; strobes already issued finish on their own.
      state_n   = IDLE;
      busy_n    = 1'b0;
      oe_n      = 1'b0;
      bit_cnt_n = '0;
    end else if (sclk_rise) begin
      bit_cnt_n = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'(BYTE_W-1)) begin
        unique case (state_q)
          CMD: begin
            addr_n = rx_byte[ADDR_W-1:0];
            if (rx_byte[CMD_RW_BIT]) begin
              state_n = RDATA;
              re_n    = 1'b1;
            end else begin
              state_n = WDATA;
            end
          end
          WDATA: begin
            wdata_n    = rx_byte;
            we_n       = 1'b1;
            inc_pend_n = 1'b1;
          end
          RDATA: begin
            // Prefetch the next byte; the last one of a frame is never shifted out.
            addr_n = addr_inc(addr_q);
            re_n   = 1'b1;
          end
          default: ;
        endcase
      end
    end else if (sclk_fall && bit_cnt_q != '0) begin
      // The fall right after a byte boundary is skipped: the next byte's MSB
      // is already on MISO.
      tx_n   = {tx_q[BYTE_W-2:0], 1'b0};
      miso_n = tx_q[BYTE_W-2];
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = oe_q;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.reg_we      = we_q;
  assign bus.reg_re      = re_q;
  assign bus.busy        = busy_q;

endmodule
